// File: rtl/chacha_arbiter.sv
// Round-robin arbiter and sequencer sharing one ChaCha core between the
// transmitter manager (index 0) and the receiver manager (index 1).
module chacha_arbiter #(
    parameter int unsigned FRAMED_DATA_WIDTH        = 512,
    parameter int unsigned CHACHA_KEY_WIDTH         = 256,
    parameter int unsigned CHACHA_NONCE_WIDTH       = 96,
    parameter int unsigned CHACHA_BLOCK_COUNT_WIDTH = 32,
    parameter int unsigned TIMEOUT_WIDTH            = 16
) (
    input  logic                                  clk,
    input  logic                                  resetN,
    // requester side
    input  logic [1:0]                            req2arb_start,
    input  logic [2*CHACHA_KEY_WIDTH-1:0]         req2arb_key,
    input  logic [2*CHACHA_NONCE_WIDTH-1:0]       req2arb_nonce,
    input  logic [2*CHACHA_BLOCK_COUNT_WIDTH-1:0] req2arb_block_count,
    input  logic [2*FRAMED_DATA_WIDTH-1:0]        req2arb_framed_data,
    output logic [1:0]                            arb2req_accept,
    output logic [1:0]                            arb2req_valid,
    output logic [1:0]                            arb2req_timeout,
    output logic [FRAMED_DATA_WIDTH-1:0]          arb2req_result,
    output logic                                  arb_busy,
    // core side
    input  logic                                  chacha2arb_ready,
    input  logic                                  chacha2arb_valid,
    input  logic [FRAMED_DATA_WIDTH-1:0]          chacha2arb_encrypted_msg,
    output logic                                  arb2chacha_start,
    output logic [CHACHA_KEY_WIDTH-1:0]           arb2chacha_key,
    output logic [CHACHA_NONCE_WIDTH-1:0]         arb2chacha_nonce,
    output logic [CHACHA_BLOCK_COUNT_WIDTH-1:0]   arb2chacha_block_count,
    output logic [FRAMED_DATA_WIDTH-1:0]          arb2chacha_framed_plaintext
);

    localparam int unsigned KW = CHACHA_KEY_WIDTH;
    localparam int unsigned NW = CHACHA_NONCE_WIDTH;
    localparam int unsigned BW = CHACHA_BLOCK_COUNT_WIDTH;
    localparam int unsigned FW = FRAMED_DATA_WIDTH;
    localparam int unsigned TW = TIMEOUT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic           grant;
    logic           grant_nxt;
    logic           last_grant;
    logic           last_grant_nxt;
    logic           pick;
    logic           req_any;
    logic [TW-1:0]  wd_cnt;
    logic [TW-1:0]  wd_cnt_nxt;
    logic           wd_expired;

    logic           capture;
    logic           load_result;
    logic [1:0]     accept_nxt;
    logic [1:0]     valid_nxt;
    logic [1:0]     timeout_nxt;
    logic           start_nxt;
    logic           busy_nxt;

    assign req_any    = |req2arb_start;
    assign wd_expired = (wd_cnt == {TW{1'b1}});

    // Arbitration: a lone request wins; on a tie the requester not served last wins.
    always_comb begin
        pick = 1'b0;
        case (req2arb_start)
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_grant;
            default: pick = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a core result beats a watchdog expiry in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_any) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (chacha2arb_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (chacha2arb_valid) begin
                    state_nxt = ST_RESPOND;
                end else if (wd_expired) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RESPOND: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output/next-value logic; every pulse computed here lands in a register.
    always_comb begin
        accept_nxt     = 2'b00;
        valid_nxt      = 2'b00;
        timeout_nxt    = 2'b00;
        start_nxt      = 1'b0;
        capture        = 1'b0;
        load_result    = 1'b0;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        wd_cnt_nxt     = wd_cnt;
        case (state)
            ST_IDLE: begin
                if (req_any) begin
                    capture    = 1'b1;
                    grant_nxt  = pick;
                    accept_nxt = {pick, ~pick};
                end
            end
            ST_ISSUE: begin
                if (chacha2arb_ready) begin
                    start_nxt  = 1'b1;
                    wd_cnt_nxt = '0;
                end
            end
            ST_WAIT: begin
                wd_cnt_nxt = wd_cnt + TW'(1);
                if (chacha2arb_valid) begin
                    load_result = 1'b1;
                    valid_nxt   = {grant, ~grant};
                end else if (wd_expired) begin
                    timeout_nxt    = {grant, ~grant};
                    last_grant_nxt = grant;
                end
            end
            ST_RESPOND: begin
                last_grant_nxt = grant;
            end
            default: begin
            end
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

    // Control registers: handshake pulses, busy flag, grant tracking, watchdog.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            arb2req_accept   <= 2'b00;
            arb2req_valid    <= 2'b00;
            arb2req_timeout  <= 2'b00;
            arb2chacha_start <= 1'b0;
            arb_busy         <= 1'b0;
            grant            <= 1'b0;
            last_grant       <= 1'b1;
            wd_cnt           <= '0;
        end else begin
            arb2req_accept   <= accept_nxt;
            arb2req_valid    <= valid_nxt;
            arb2req_timeout  <= timeout_nxt;
            arb2chacha_start <= start_nxt;
            arb_busy         <= busy_nxt;
            grant            <= grant_nxt;
            last_grant       <= last_grant_nxt;
            wd_cnt           <= wd_cnt_nxt;
        end
    end

    // Operand capture from the granted requester; held until the next grant.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            arb2chacha_key              <= '0;
            arb2chacha_nonce            <= '0;
            arb2chacha_block_count      <= '0;
            arb2chacha_framed_plaintext <= '0;
        end else if (capture) begin
            arb2chacha_key              <= pick ? req2arb_key[KW +: KW]
                                                : req2arb_key[0 +: KW];
            arb2chacha_nonce            <= pick ? req2arb_nonce[NW +: NW]
                                                : req2arb_nonce[0 +: NW];
            arb2chacha_block_count      <= pick ? req2arb_block_count[BW +: BW]
                                                : req2arb_block_count[0 +: BW];
            arb2chacha_framed_plaintext <= pick ? req2arb_framed_data[FW +: FW]
                                                : req2arb_framed_data[0 +: FW];
        end
    end

    // Result register; untouched on timeout so the last good result stays visible.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            arb2req_result <= '0;
        end else if (load_result) begin
            arb2req_result <= chacha2arb_encrypted_msg;
        end
    end

endmodule

// File: tb/tb_chacha_arbiter.sv
// Directed bench for chacha_arbiter: a default-width instance plus a
// TIMEOUT_WIDTH=3 instance for the watchdog cases, both on shared stimulus.
module tb_chacha_arbiter;

    localparam int unsigned FW = 512;
    localparam int unsigned KW = 256;
    localparam int unsigned NW = 96;
    localparam int unsigned BW = 32;

    logic          clk = 1'b0;
    logic          resetN;
    logic [1:0]    req_start;
    logic [2*KW-1:0] req_key;
    logic [2*NW-1:0] req_nonce;
    logic [2*BW-1:0] req_bc;
    logic [2*FW-1:0] req_data;
    logic          core_ready;
    logic          core_valid;
    logic [FW-1:0] core_msg;

    // main instance outputs
    logic [1:0]    accept, valid, timeout;
    logic [FW-1:0] result;
    logic          busy;
    logic          c_start;
    logic [KW-1:0] c_key;
    logic [NW-1:0] c_nonce;
    logic [BW-1:0] c_bc;
    logic [FW-1:0] c_pt;

    // watchdog instance outputs
    logic [1:0]    wd_accept, wd_valid, wd_timeout;
    logic [FW-1:0] wd_result;
    logic          wd_busy;
    logic          wd_start;
    logic [KW-1:0] wd_key;
    logic [NW-1:0] wd_nonce;
    logic [BW-1:0] wd_bc;
    logic [FW-1:0] wd_pt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    chacha_arbiter dut (
        .clk                        (clk),
        .resetN                     (resetN),
        .req2arb_start              (req_start),
        .req2arb_key                (req_key),
        .req2arb_nonce              (req_nonce),
        .req2arb_block_count        (req_bc),
        .req2arb_framed_data        (req_data),
        .arb2req_accept             (accept),
        .arb2req_valid              (valid),
        .arb2req_timeout            (timeout),
        .arb2req_result             (result),
        .arb_busy                   (busy),
        .chacha2arb_ready           (core_ready),
        .chacha2arb_valid           (core_valid),
        .chacha2arb_encrypted_msg   (core_msg),
        .arb2chacha_start           (c_start),
        .arb2chacha_key             (c_key),
        .arb2chacha_nonce           (c_nonce),
        .arb2chacha_block_count     (c_bc),
        .arb2chacha_framed_plaintext(c_pt)
    );

    chacha_arbiter #(.TIMEOUT_WIDTH(3)) dut_wd (
        .clk                        (clk),
        .resetN                     (resetN),
        .req2arb_start              (req_start),
        .req2arb_key                (req_key),
        .req2arb_nonce              (req_nonce),
        .req2arb_block_count        (req_bc),
        .req2arb_framed_data        (req_data),
        .arb2req_accept             (wd_accept),
        .arb2req_valid              (wd_valid),
        .arb2req_timeout            (wd_timeout),
        .arb2req_result             (wd_result),
        .arb_busy                   (wd_busy),
        .chacha2arb_ready           (core_ready),
        .chacha2arb_valid           (core_valid),
        .chacha2arb_encrypted_msg   (core_msg),
        .arb2chacha_start           (wd_start),
        .arb2chacha_key             (wd_key),
        .arb2chacha_nonce           (wd_nonce),
        .arb2chacha_block_count     (wd_bc),
        .arb2chacha_framed_plaintext(wd_pt)
    );

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetN     = 1'b0;
        req_start  = 2'b00;
        core_ready = 1'b1;
        core_valid = 1'b0;
        core_msg   = '0;
        repeat (2) step();
        resetN = 1'b1;
    endtask

    // serve one grant on the main instance starting from IDLE with core ready
    task automatic serve(input int idx, input logic [KW-1:0] k, input logic [FW-1:0] m);
        logic [1:0] oh;
        oh = (idx == 1) ? 2'b10 : 2'b01;
        step();
        check("srv_accept", FW'(accept), FW'(oh));
        req_start[idx] = 1'b0;
        step();
        check("srv_start", FW'(c_start), FW'(1'b1));
        check("srv_key", FW'(c_key), FW'(k));
        core_valid = 1'b1;
        core_msg   = m;
        step();
        check("srv_valid", FW'(valid), FW'(oh));
        check("srv_result", result, m);
        core_valid = 1'b0;
        core_msg   = '0;
        step();
        check("srv_idle", FW'(busy), FW'(1'b0));
    endtask

    logic [KW-1:0] key_a, key_b;
    logic [FW-1:0] msg_a5, msg_b, msg_c;

    initial begin
        key_a  = {32'hDEADBEEF, 192'h0, 32'hC0FFEBE2};
        key_b  = {32'h01234567, 192'h0, 32'h89ABCDEF};
        msg_a5 = {64{8'hA5}};
        msg_b  = {64{8'h3C}};
        msg_c  = {64{8'h81}};
        req_key   = {key_b, key_a};
        req_nonce = {96'h1111, 96'h0};
        req_bc    = {32'h00000007, 32'hFADECAFE};
        req_data  = {{64{8'h77}}, {64{8'h5A}}};

        // ---- reset values
        do_reset();
        resetN = 1'b0;
        step();
        check("rst_accept", FW'(accept), '0);
        check("rst_busy", FW'(busy), '0);
        check("rst_start", FW'(c_start), '0);
        check("rst_key", FW'(c_key), '0);
        check("rst_result", result, '0);
        resetN = 1'b1;

        // ---- single request, 10-cycle core latency
        req_start = 2'b01;
        step();
        check("t1_accept", FW'(accept), FW'(2'b01));
        check("t1_busy", FW'(busy), FW'(1'b1));
        check("t1_no_start", FW'(c_start), '0);
        req_start = 2'b00;
        step();
        check("t1_start", FW'(c_start), FW'(1'b1));
        check("t1_accept_off", FW'(accept), '0);
        check("t1_key", FW'(c_key), FW'(key_a));
        check("t1_nonce", FW'(c_nonce), '0);
        check("t1_bc", FW'(c_bc), FW'(32'hFADECAFE));
        check("t1_pt", c_pt, {64{8'h5A}});
        repeat (9) step();
        check("t1_wait_busy", FW'(busy), FW'(1'b1));
        check("t1_wait_novalid", FW'(valid), '0);
        core_valid = 1'b1;
        core_msg   = msg_a5;
        step();
        check("t1_valid", FW'(valid), FW'(2'b01));
        check("t1_result", result, msg_a5);
        core_valid = 1'b0;
        core_msg   = '0;
        step();
        check("t1_valid_off", FW'(valid), '0);
        check("t1_busy_off", FW'(busy), '0);
        check("t1_result_held", result, msg_a5);

        // ---- simultaneous requests, twice: 0 then 1 each round
        do_reset();
        for (int r = 0; r < 2; r++) begin
            req_start = 2'b11;
            serve(0, key_a, msg_b);
            serve(1, key_b, msg_c);
        end

        // ---- core not ready for 5 cycles in ISSUE
        do_reset();
        core_ready = 1'b0;
        req_start  = 2'b01;
        step();
        check("t3_accept", FW'(accept), FW'(2'b01));
        req_start = 2'b00;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_hold_start", FW'(c_start), '0);
        end
        core_ready = 1'b1;
        step();
        check("t3_start", FW'(c_start), FW'(1'b1));
        step();
        check("t3_single_start", FW'(c_start), '0);

        // ---- watchdog expiry with TIMEOUT_WIDTH=3
        do_reset();
        req_start = 2'b01;
        step();
        check("t4_accept", FW'(wd_accept), FW'(2'b01));
        req_start = 2'b00;
        step();
        check("t4_start", FW'(wd_start), FW'(1'b1));
        check("t4_key", FW'(wd_key), FW'(key_a));
        core_msg = msg_c;
        for (int i = 0; i < 7; i++) begin
            step();
            check("t4_no_timeout", FW'(wd_timeout), '0);
        end
        step();
        check("t4_timeout", FW'(wd_timeout), FW'(2'b01));
        check("t4_no_valid", FW'(wd_valid), '0);
        check("t4_result_kept", wd_result, '0);
        check("t4_idle", FW'(wd_busy), '0);
        step();
        check("t4_timeout_off", FW'(wd_timeout), '0);

        // ---- valid on the 8th WAIT cycle wins over expiry
        do_reset();
        req_start = 2'b01;
        step();
        req_start = 2'b00;
        step();
        repeat (7) step();
        core_valid = 1'b1;
        core_msg   = msg_b;
        step();
        check("t4b_valid", FW'(wd_valid), FW'(2'b01));
        check("t4b_no_timeout", FW'(wd_timeout), '0);
        check("t4b_result", wd_result, msg_b);
        core_valid = 1'b0;
        core_msg   = '0;
        step();
        check("t4b_timeout_off", FW'(wd_timeout), '0);
        check("t4b_idle", FW'(wd_busy), '0);

        // ---- reset mid-WAIT, stray late valid
        do_reset();
        req_start = 2'b10;
        step();
        check("t5_accept", FW'(accept), FW'(2'b10));
        req_start = 2'b00;
        repeat (3) step();
        resetN = 1'b0;
        step();
        check("t5_rst_busy", FW'(busy), '0);
        check("t5_rst_key", FW'(c_key), '0);
        check("t5_rst_valid", FW'(valid), '0);
        resetN     = 1'b1;
        core_valid = 1'b1;
        core_msg   = msg_a5;
        step();
        check("t5_stray_valid", FW'(valid), '0);
        check("t5_stray_timeout", FW'(timeout), '0);
        check("t5_stray_result", result, '0);
        check("t5_stray_busy", FW'(busy), '0);
        core_valid = 1'b0;
        core_msg   = '0;
        req_start  = 2'b11;
        step();
        check("t5_regrant", FW'(accept), FW'(2'b01));
        req_start = 2'b00;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
